// File: rtl/task_output_pkt_streamer_pkg.sv
// Shared types and per-task constants for the task answer-path packet streamer.
package task_output_pkt_streamer_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2
    } task_out_state_e;

    // Maximum packet lengths handed to each task wrapper's streamer instance.
    localparam int unsigned TASK_0_PKT_WORDS = 4;
    localparam int unsigned TASK_1_PKT_WORDS = 8;
    localparam int unsigned TASK_2_PKT_WORDS = 16;

endpackage

// File: rtl/task_output_pkt_streamer_if.sv
// Core-to-streamer and streamer-to-manager signal bundle.
interface task_output_pkt_streamer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SIZE_W = 12
);
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid;
    logic              i_data_last;
    logic              i_tmanager_ready;
    logic              o_tanswer_ready;
    logic [DATA_W-1:0] o_tdata;
    logic              o_tanswer_data_last;
    logic [SIZE_W-1:0] o_packet_size_in_bytes;

    modport slave (
        input  i_data, i_data_valid, i_data_last, i_tmanager_ready,
        output o_tanswer_ready, o_tdata, o_tanswer_data_last, o_packet_size_in_bytes
    );

    modport master (
        output i_data, i_data_valid, i_data_last, i_tmanager_ready,
        input  o_tanswer_ready, o_tdata, o_tanswer_data_last, o_packet_size_in_bytes
    );
endinterface

// File: rtl/task_output_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous clear; q is the head word.
module task_output_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              empty,
    output logic              full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       fill;

    // Extra pointer bit distinguishes full from empty; fill works for DEPTH=1 too.
    assign fill  = wptr - rptr;
    assign empty = (fill == '0);
    assign full  = (fill == (AW+1)'(DEPTH));
    assign q     = mem[rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr && !full)  wptr <= wptr + (AW+1)'(1);
            if (rd && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr && !full) mem[wptr[AW-1:0]] <= d;
    end
endmodule

// File: rtl/task_output_pkt_streamer.sv
// Buffers task result words into packets and streams them to the task manager
// with ready/ready handshake, last flag, byte count and sticky overflow.
module task_output_pkt_streamer
    import task_output_pkt_streamer_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PKT_WORDS = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned SIZE_W    = 12
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    task_output_pkt_streamer_if.slave   bus,
    output logic                        o_busy,
    output logic                        o_full,
    output logic                        o_overflow
);
    localparam int unsigned CNT_W = $clog2(PKT_WORDS + 1);
    localparam int unsigned BYTES = DATA_W / 8;

    task_out_state_e   state, state_n;
    logic [CNT_W-1:0]  wcnt, wcnt_n, rcnt, rcnt_n, len, len_n;
    logic              ready_q, ready_n, last_q, last_n;
    logic              busy_q, busy_n, ovf_q, ovf_n;
    logic [SIZE_W-1:0] size_q, size_n;
    logic              fifo_wr, fifo_rd, fifo_empty, fifo_full, xfer;
    logic [DATA_W-1:0] fifo_q;

    task_output_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .clr   (i_rst),
        .wr    (fifo_wr),
        .rd    (fifo_rd),
        .d     (bus.i_data),
        .q     (fifo_q),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        rcnt_n  = rcnt;
        len_n   = len;
        ready_n = ready_q;
        last_n  = last_q;
        size_n  = size_q;
        ovf_n   = ovf_q;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        xfer    = ready_q && bus.i_tmanager_ready;

        if (bus.i_data_valid && (state != S_LOAD || fifo_full)) ovf_n = 1'b1;

        case (state)
            S_LOAD: begin
                if (bus.i_data_valid && !fifo_full) begin
                    fifo_wr = 1'b1;
                    wcnt_n  = wcnt + CNT_W'(1);
                    if (bus.i_data_last || wcnt == CNT_W'(PKT_WORDS - 1)) begin
                        len_n   = wcnt + CNT_W'(1);
                        wcnt_n  = '0;
                        state_n = S_START;
                    end
                end
            end
            S_START: begin
                size_n  = SIZE_W'(len) * SIZE_W'(BYTES);
                ready_n = 1'b1;
                rcnt_n  = '0;
                last_n  = (len == CNT_W'(1));
                state_n = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    fifo_rd = !fifo_empty;
                    rcnt_n  = rcnt + CNT_W'(1);
                    if (last_q) begin
                        ready_n = 1'b0;
                        last_n  = 1'b0;
                        size_n  = '0;
                        state_n = S_LOAD;
                    end else begin
                        // Flag the word that will be at the head after this pop.
                        last_n  = (rcnt_n == len - CNT_W'(1));
                    end
                end
            end
            default: state_n = S_LOAD;
        endcase

        busy_n = (state_n != S_LOAD);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_LOAD;
            wcnt    <= '0;
            rcnt    <= '0;
            len     <= '0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            size_q  <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_n;
            wcnt    <= wcnt_n;
            rcnt    <= rcnt_n;
            len     <= len_n;
            ready_q <= ready_n;
            last_q  <= last_n;
            size_q  <= size_n;
            busy_q  <= busy_n;
            ovf_q   <= ovf_n;
        end
    end

    assign bus.o_tanswer_ready        = ready_q;
    assign bus.o_tdata                = ready_q ? fifo_q : '0;
    assign bus.o_tanswer_data_last    = last_q;
    assign bus.o_packet_size_in_bytes = size_q;
    assign o_busy                     = busy_q;
    assign o_full                     = busy_q;
    assign o_overflow                 = ovf_q;
endmodule

// File: tb/tb_task_output_pkt_streamer.sv
// Bench for task_output_pkt_streamer: a narrow (8-bit, 4-word) and a wide
// (32-bit, 8-word) instance driven from scenario tasks against a packet model.
module tb_task_output_pkt_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    task_output_pkt_streamer_if #(.DATA_W(8),  .SIZE_W(12)) ba ();
    task_output_pkt_streamer_if #(.DATA_W(32), .SIZE_W(12)) bw ();
    logic a_busy, a_full, a_ovf, w_busy, w_full, w_ovf;

    task_output_pkt_streamer #(.DATA_W(8), .PKT_WORDS(4), .DEPTH(4), .SIZE_W(12)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(ba.slave),
        .o_busy(a_busy), .o_full(a_full), .o_overflow(a_ovf)
    );
    task_output_pkt_streamer #(.DATA_W(32), .PKT_WORDS(8), .DEPTH(8), .SIZE_W(12)) dut_w (
        .i_clk(clk), .i_rst(rst), .bus(bw.slave),
        .o_busy(w_busy), .o_full(w_full), .o_overflow(w_ovf)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Words accepted by the manager in the last collect() call.
    logic [31:0] cap_d[$];
    logic        cap_l[$];
    logic [11:0] cap_s[$];
    int          cap_c[$];
    int          hold_err;
    bit          tmo;

    task automatic idle_inputs();
        ba.i_data_valid = 1'b0; ba.i_data_last = 1'b0;
        bw.i_data_valid = 1'b0; bw.i_data_last = 1'b0;
    endtask

    task automatic set_ready(input bit wide, input logic r);
        if (wide) bw.i_tmanager_ready = r; else ba.i_tmanager_ready = r;
    endtask

    task automatic write_word(input bit wide, input logic [31:0] d, input logic last);
        @(negedge clk);
        idle_inputs();
        if (wide) begin bw.i_data = d; bw.i_data_valid = 1'b1; bw.i_data_last = last; end
        else begin ba.i_data = d[7:0]; ba.i_data_valid = 1'b1; ba.i_data_last = last; end
    endtask

    task automatic junk_cycle(input bit wide);
        @(negedge clk);
        idle_inputs();
        if (wide) bw.i_data_last = 1'($urandom_range(0, 1));
        else ba.i_data_last = 1'($urandom_range(0, 1));
    endtask

    // mode 0: manager always ready; 1: ready pattern 1,0,0; 2: random ready.
    task automatic collect(input bit wide, input int n_max, input int mode, input int inject);
        logic r, o_r, l, pl;
        logic [31:0] d, pd;
        logic [11:0] s, ps;
        bit stall;
        stall = 0; pd = '0; pl = 1'b0; ps = '0;
        cap_d.delete(); cap_l.delete(); cap_s.delete(); cap_c.delete();
        hold_err = 0;
        tmo = 1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            idle_inputs();
            if (cyc == inject) begin ba.i_data = 8'hEE; ba.i_data_valid = 1'b1; ba.i_data_last = 1'b1; end
            if (wide) begin
                o_r = bw.o_tanswer_ready; d = bw.o_tdata;
                l = bw.o_tanswer_data_last; s = bw.o_packet_size_in_bytes;
            end else begin
                o_r = ba.o_tanswer_ready; d = {24'h0, ba.o_tdata};
                l = ba.o_tanswer_data_last; s = ba.o_packet_size_in_bytes;
            end
            if (stall && (o_r !== 1'b1 || d !== pd || l !== pl || s !== ps)) hold_err++;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            set_ready(wide, r);
            stall = o_r && !r;
            pd = d; pl = l; ps = s;
            if (o_r === 1'b1 && r) begin
                cap_d.push_back(d); cap_l.push_back(l); cap_s.push_back(s); cap_c.push_back(cyc);
                if (l === 1'b1 || cap_d.size() >= n_max) begin tmo = 0; break; end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        ba.i_data = '0; bw.i_data = '0;
        set_ready(0, 1'b0); set_ready(1, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({ba.o_tanswer_ready, ba.o_tanswer_data_last, ba.o_tdata, ba.o_packet_size_in_bytes, a_busy, a_full, a_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got rdy=%b last=%b data=%h size=%0d busy=%b full=%b ovf=%b, want all 0",
                     ba.o_tanswer_ready, ba.o_tanswer_data_last, ba.o_tdata, ba.o_packet_size_in_bytes, a_busy, a_full, a_ovf);
        end
        n_assert++;
        if ({bw.o_tanswer_ready, bw.o_tanswer_data_last, bw.o_tdata, bw.o_packet_size_in_bytes, w_busy, w_full, w_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_w: got rdy=%b last=%b data=%h size=%0d busy=%b, want all 0",
                     bw.o_tanswer_ready, bw.o_tanswer_data_last, bw.o_tdata, bw.o_packet_size_in_bytes, w_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_length();
        logic [31:0] exp[$];
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        foreach (exp[i]) write_word(0, exp[i], 1'b0);
        @(negedge clk);
        idle_inputs();
        n_assert++;
        if (a_busy !== 1'b1 || a_full !== 1'b1 || ba.o_tanswer_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_start: got busy=%b full=%b rdy=%b, want busy=1 full=1 rdy=0", a_busy, a_full, ba.o_tanswer_ready);
        end
        set_ready(0, 1'b1);
        collect(0, 64, 0, -1);
        n_assert++;
        if (tmo || cap_d.size() != exp.size()) begin
            n_fail++; $display("FAIL full_count: got %0d words timeout=%0b, want %0d", cap_d.size(), tmo, exp.size());
        end
        for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
            n_assert++;
            if (cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1) || cap_s[i] !== 12'd4 || cap_c[i] != i) begin
                n_fail++;
                $display("FAIL full_word%0d: got d=%h last=%b size=%0d cyc=%0d, want d=%h last=%0b size=4 cyc=%0d",
                         i, cap_d[i], cap_l[i], cap_s[i], cap_c[i], exp[i], (i == exp.size() - 1), i);
            end
        end
        @(negedge clk);
        n_assert++;
        if ({ba.o_tanswer_ready, ba.o_tanswer_data_last, ba.o_packet_size_in_bytes, a_busy} !== '0) begin
            n_fail++;
            $display("FAIL full_end: got rdy=%b last=%b size=%0d busy=%b, want all 0",
                     ba.o_tanswer_ready, ba.o_tanswer_data_last, ba.o_packet_size_in_bytes, a_busy);
        end
    endtask

    task automatic test_early_last();
        logic [31:0] exp[$];
        junk_cycle(0);
        ba.i_data_last = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_assert++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL last_no_valid: got busy=%b, want 0", a_busy); end
        for (int p = 0; p < 2; p++) begin
            exp = (p == 0) ? '{32'hA0, 32'hA1} : '{32'h5A};
            foreach (exp[i]) write_word(0, exp[i], i == exp.size() - 1);
            collect(0, 64, 0, -1);
            n_assert++;
            if (tmo || cap_d.size() != exp.size()) begin
                n_fail++; $display("FAIL early_count%0d: got %0d words timeout=%0b, want %0d", p, cap_d.size(), tmo, exp.size());
            end
            for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
                n_assert++;
                if (cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1) || cap_s[i] !== 12'(exp.size())) begin
                    n_fail++;
                    $display("FAIL early%0d_word%0d: got d=%h last=%b size=%0d, want d=%h last=%0b size=%0d",
                             p, i, cap_d[i], cap_l[i], cap_s[i], exp[i], (i == exp.size() - 1), exp.size());
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp[$];
        exp.delete();
        repeat (4) exp.push_back(32'($urandom_range(0, 255)));
        foreach (exp[i]) write_word(0, exp[i], 1'b0);
        collect(0, 64, 1, -1);
        n_assert++;
        if (tmo || cap_d.size() != 4 || hold_err != 0) begin
            n_fail++; $display("FAIL bp_count: got %0d words timeout=%0b hold_err=%0d, want 4 words 0 hold_err", cap_d.size(), tmo, hold_err);
        end
        for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
            n_assert++;
            if (cap_d[i] !== exp[i] || cap_l[i] !== (i == 3) || cap_s[i] !== 12'd4) begin
                n_fail++;
                $display("FAIL bp_word%0d: got d=%h last=%b size=%0d, want d=%h last=%0b size=4", i, cap_d[i], cap_l[i], cap_s[i], exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] exp[$];
        exp = '{32'h0F, 32'hF0, 32'h3C, 32'hC3};
        foreach (exp[i]) write_word(0, exp[i], i == 3);
        collect(0, 64, 2, -1);
        n_assert++;
        if (tmo || cap_d.size() != 4) begin
            n_fail++; $display("FAIL bound_count: got %0d words timeout=%0b, want 4", cap_d.size(), tmo);
        end
        for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
            n_assert++;
            if (cap_d[i] !== exp[i] || cap_l[i] !== (i == 3) || cap_s[i] !== 12'd4) begin
                n_fail++;
                $display("FAIL bound_word%0d: got d=%h last=%b size=%0d, want d=%h last=%0b size=4", i, cap_d[i], cap_l[i], cap_s[i], exp[i], (i == 3));
            end
        end
        repeat (3) @(negedge clk);
        n_assert++;
        if (a_busy !== 1'b0 || ba.o_tanswer_ready !== 1'b0) begin
            n_fail++; $display("FAIL bound_single: got busy=%b rdy=%b after packet, want 0 0", a_busy, ba.o_tanswer_ready);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp[$];
        n_assert++;
        if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got ovf=%b, want 0", a_ovf); end
        for (int p = 0; p < 2; p++) begin
            exp.delete();
            repeat (4 - p) exp.push_back(32'($urandom_range(0, 200)));
            foreach (exp[i]) write_word(0, exp[i], i == exp.size() - 1);
            collect(0, 64, (p == 0) ? 0 : 2, (p == 0) ? 2 : -1);
            n_assert++;
            if (tmo || cap_d.size() != exp.size()) begin
                n_fail++; $display("FAIL ovf_count%0d: got %0d words timeout=%0b, want %0d", p, cap_d.size(), tmo, exp.size());
            end
            for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
                n_assert++;
                if (cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1) || cap_s[i] !== 12'(exp.size())) begin
                    n_fail++;
                    $display("FAIL ovf%0d_word%0d: got d=%h last=%b size=%0d, want d=%h last=%0b size=%0d",
                             p, i, cap_d[i], cap_l[i], cap_s[i], exp[i], (i == exp.size() - 1), exp.size());
                end
            end
            @(negedge clk);
            n_assert++;
            if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky%0d: got ovf=%b, want 1", p, a_ovf); end
        end
    endtask

    task automatic test_reset_in_send();
        logic [31:0] exp[$];
        exp = '{32'h91, 32'h92, 32'h93, 32'h94};
        foreach (exp[i]) write_word(0, exp[i], 1'b0);
        collect(0, 2, 0, -1);
        n_assert++;
        if (tmo || cap_d.size() != 2 || cap_d[0] !== 32'h91 || cap_d[1] !== 32'h92) begin
            n_fail++; $display("FAIL rst_prefix: got %0d words, want 91 92", cap_d.size());
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_assert++;
        if ({ba.o_tanswer_ready, ba.o_tanswer_data_last, ba.o_tdata, ba.o_packet_size_in_bytes, a_busy, a_full, a_ovf} !== '0) begin
            n_fail++;
            $display("FAIL rst_send: got rdy=%b last=%b data=%h size=%0d busy=%b full=%b ovf=%b, want all 0",
                     ba.o_tanswer_ready, ba.o_tanswer_data_last, ba.o_tdata, ba.o_packet_size_in_bytes, a_busy, a_full, a_ovf);
        end
        rst = 1'b0;
        exp = '{32'h01, 32'h02, 32'h03, 32'h04};
        foreach (exp[i]) write_word(0, exp[i], 1'b0);
        collect(0, 64, 0, -1);
        n_assert++;
        if (tmo || cap_d.size() != 4) begin
            n_fail++; $display("FAIL rst_count: got %0d words timeout=%0b, want 4", cap_d.size(), tmo);
        end
        for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
            n_assert++;
            if (cap_d[i] !== exp[i] || cap_l[i] !== (i == 3) || cap_s[i] !== 12'd4) begin
                n_fail++;
                $display("FAIL rst_word%0d: got d=%h last=%b size=%0d, want d=%h last=%0b size=4", i, cap_d[i], cap_l[i], cap_s[i], exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_wide();
        logic [31:0] exp[$];
        int n;
        for (int p = 0; p < 3; p++) begin
            n = (p == 2) ? 5 : 8;
            exp.delete();
            repeat (n) exp.push_back($urandom);
            foreach (exp[i]) write_word(1, exp[i], (p == 2) && (i == n - 1));
            collect(1, 64, p, -1);
            n_assert++;
            if (tmo || cap_d.size() != n) begin
                n_fail++; $display("FAIL wide_count%0d: got %0d words timeout=%0b, want %0d", p, cap_d.size(), tmo, n);
            end
            for (int i = 0; i < n && i < cap_d.size(); i++) begin
                n_assert++;
                if (cap_d[i] !== exp[i] || cap_l[i] !== (i == n - 1) || cap_s[i] !== 12'(n * 4)) begin
                    n_fail++;
                    $display("FAIL wide%0d_word%0d: got d=%h last=%b size=%0d, want d=%h last=%0b size=%0d",
                             p, i, cap_d[i], cap_l[i], cap_s[i], exp[i], (i == n - 1), n * 4);
                end
            end
        end
        @(negedge clk);
        n_assert++;
        if (w_busy !== 1'b0 || w_ovf !== 1'b0 || bw.o_packet_size_in_bytes !== 12'd0) begin
            n_fail++; $display("FAIL wide_end: got busy=%b ovf=%b size=%0d, want 0 0 0", w_busy, w_ovf, bw.o_packet_size_in_bytes);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp[$];
        int n;
        for (int p = 0; p < 25; p++) begin
            n = $urandom_range(1, 4);
            exp.delete();
            repeat (n) exp.push_back(32'($urandom_range(0, 255)));
            foreach (exp[i]) begin
                if ($urandom_range(0, 3) == 0) junk_cycle(0);
                write_word(0, exp[i], (i == n - 1) && (n < 4 || $urandom_range(0, 1) == 1));
            end
            collect(0, 64, 2, -1);
            n_assert++;
            if (tmo || cap_d.size() != n) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d words timeout=%0b, want %0d", p, cap_d.size(), tmo, n);
            end
            for (int i = 0; i < n && i < cap_d.size(); i++) begin
                n_assert++;
                if (cap_d[i] !== exp[i] || cap_l[i] !== (i == n - 1) || cap_s[i] !== 12'(n) || hold_err != 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_word%0d: got d=%h last=%b size=%0d hold_err=%0d, want d=%h last=%0b size=%0d",
                             p, i, cap_d[i], cap_l[i], cap_s[i], hold_err, exp[i], (i == n - 1), n);
                end
            end
        end
        @(negedge clk);
        n_assert++;
        if (a_ovf !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL rand_end: got ovf=%b busy=%b, want 0 0", a_ovf, a_busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_length();
        test_early_last();
        test_back_pressure();
        test_boundary();
        test_overflow();
        test_reset_in_send();
        test_wide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
